// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle shift/rotate controller for the 8-bit datapath. Any amount
//   0..255 is applied by iterating four 3-bit-amount shift units
//   (left, right, arithmetic_right, rotate_right) on an accumulator, at most
//   MAX_STEP bit positions per RUN cycle.
//
// Ports:
//   CLK     in   1  clock, rising edge
//   RESET   in   1  synchronous active-high reset (priority over START)
//   START   in   1  request strobe, sampled only in IDLE
//   OPCODE  in   2  00 SLL, 01 SRL, 10 SRA, 11 ROR
//   DATA    in   8  operand, latched at accept
//   AMOUNT  in   8  shift amount, latched at accept
//   RESULT  out  8  registered result, updated only on completion
//   BUSY    out  1  high while in RUN
//   DONE    out  1  one-cycle completion pulse
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// left: logical shift left by 0..7.
//   DATA in 8, SHIFT in 3, RESULT out 8
// ---------------------------------------------------------------------------
module left (
  input  logic [7:0] DATA,
  input  logic [2:0] SHIFT,
  output logic [7:0] RESULT
);
  assign RESULT = DATA << SHIFT;
endmodule

// ---------------------------------------------------------------------------
// right: logical shift right by 0..7.
//   DATA in 8, SHIFT in 3, RESULT out 8
// ---------------------------------------------------------------------------
module right (
  input  logic [7:0] DATA,
  input  logic [2:0] SHIFT,
  output logic [7:0] RESULT
);
  assign RESULT = DATA >> SHIFT;
endmodule

// ---------------------------------------------------------------------------
// arithmetic_right: sign-filling shift right by 0..7.
//   DATA in 8, SHIFT in 3, RESULT out 8
// ---------------------------------------------------------------------------
module arithmetic_right (
  input  logic [7:0] DATA,
  input  logic [2:0] SHIFT,
  output logic [7:0] RESULT
);
  logic signed [7:0] sdata;

  assign sdata  = DATA;
  assign RESULT = sdata >>> SHIFT;
endmodule

// ---------------------------------------------------------------------------
// rotate_right: rotate right by 0..7.
//   DATA in 8, SHIFT in 3, RESULT out 8
// ---------------------------------------------------------------------------
module rotate_right (
  input  logic [7:0] DATA,
  input  logic [2:0] SHIFT,
  output logic [7:0] RESULT
);
  logic [15:0] dbl;

  // Shifting the doubled word right leaves the rotated byte in the low half.
  assign dbl    = {DATA, DATA} >> SHIFT;
  assign RESULT = dbl[7:0];
endmodule

// ---------------------------------------------------------------------------
// shift_sequencer top
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int unsigned MAX_STEP    = 7,    // 1..7 bit positions per RUN cycle
  parameter bit          FAST_ROTATE = 1'b1  // reduce ROR amount mod 8 at accept
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] OPCODE,
  input  logic [7:0] DATA,
  input  logic [7:0] AMOUNT,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  localparam logic [7:0] STEP_MAX = 8'(MAX_STEP);

  state_t     state;
  op_t        op;
  logic [7:0] acc;
  logic [7:0] rem;
  logic [7:0] result_q;

  logic [7:0] step;
  logic [7:0] rem_next;
  logic [2:0] shift;
  logic [7:0] eff_amount;
  logic       saturated;

  logic [7:0] sll_out;
  logic [7:0] srl_out;
  logic [7:0] sra_out;
  logic [7:0] ror_out;
  logic [7:0] unit_out;

  // All four units see the same accumulator and amount; only the latched
  // opcode's output is consumed.
  left u_left (
    .DATA   (acc),
    .SHIFT  (shift),
    .RESULT (sll_out)
  );

  right u_right (
    .DATA   (acc),
    .SHIFT  (shift),
    .RESULT (srl_out)
  );

  arithmetic_right u_arithmetic_right (
    .DATA   (acc),
    .SHIFT  (shift),
    .RESULT (sra_out)
  );

  rotate_right u_rotate_right (
    .DATA   (acc),
    .SHIFT  (shift),
    .RESULT (ror_out)
  );

  // Amount actually iterated for the incoming request. Rotation by 8 is the
  // identity, so the fast path keeps only the low three bits.
  always_comb begin
    eff_amount = AMOUNT;
    if (FAST_ROTATE && (op_t'(OPCODE) == OP_ROR)) begin
      eff_amount = {5'b0, AMOUNT[2:0]};
    end
  end

  // Per-cycle chunk: min(rem, MAX_STEP). STEP_MAX <= 7 keeps it in 3 bits.
  always_comb begin
    step     = (rem < STEP_MAX) ? rem : STEP_MAX;
    rem_next = rem - step;
    shift    = step[2:0];
  end

  always_comb begin
    unit_out = sll_out;
    unique case (op)
      OP_SLL: unit_out = sll_out;
      OP_SRL: unit_out = srl_out;
      OP_SRA: unit_out = sra_out;
      OP_ROR: unit_out = ror_out;
    endcase
  end

  // Once the accumulator reaches a fixed point of the selected shift, further
  // iterations cannot change it, so the remaining amount is irrelevant.
  always_comb begin
    saturated = 1'b0;
    unique case (op)
      OP_SLL: saturated = (acc == 8'h00);
      OP_SRL: saturated = (acc == 8'h00);
      OP_SRA: saturated = (acc == 8'h00) || (acc == 8'hFF);
      OP_ROR: saturated = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      op       <= OP_SLL;
      acc      <= '0;
      rem      <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            acc <= DATA;
            op  <= op_t'(OPCODE);
            rem <= eff_amount;
            if (eff_amount == 8'h00) begin
              result_q <= DATA;
              state    <= FIN;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (saturated) begin
            result_q <= acc;
            state    <= FIN;
          end else begin
            acc <= unit_out;
            rem <= rem_next;
            if (rem_next == 8'h00) begin
              result_q <= unit_out;
              state    <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign RESULT = result_q;
  assign BUSY   = (state == RUN);
  assign DONE   = (state == FIN);

endmodule
